// File: rtl/rv_plic_gw_pkg.sv
// rtl/rv_plic_gw_pkg.sv - shared types and helpers for the PLIC source gateway
package rv_plic_gw_pkg;

    typedef enum logic {
        GW_LEVEL = 1'b0,
        GW_EDGE  = 1'b1
    } gw_mode_e;

    // ID width able to hold 0 ("no interrupt") plus IDs 1..n
    function automatic int srcw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rv_plic_gw_id_decode.sv
// rtl/rv_plic_gw_id_decode.sv - per-target strobe+ID buses to a one-hot-per-source hit vector
module rv_plic_gw_id_decode
    import rv_plic_gw_pkg::*;
#(
    parameter int N_SOURCE = 32,
    parameter int N_TARGET = 1,
    parameter int SRCW     = srcw(N_SOURCE)
) (
    input  logic [N_TARGET-1:0]      strobe_i,
    input  logic [N_TARGET*SRCW-1:0] id_i,
    output logic [N_SOURCE-1:0]      hit_o
);

    // Source k only ever matches ID k+1, so ID 0 and IDs beyond N_SOURCE
    // fall out naturally; several targets naming one ID collapse into one hit.
    always_comb begin
        hit_o = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            for (int k = 0; k < N_SOURCE; k++) begin
                if (strobe_i[t] && (id_i[t*SRCW +: SRCW] == SRCW'(k + 1))) begin
                    hit_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rv_plic_gateway_cc.sv
// rtl/rv_plic_gateway_cc.sv - PLIC source gateway with claim/complete tracking (optional RV_PLIC_GATEWAY_SYNC_EN input synchronizer)
module rv_plic_gateway_cc
    import rv_plic_gw_pkg::*;
#(
    parameter  int N_SOURCE = 32,
    parameter  int N_TARGET = 1,
    localparam int SRCW     = srcw(N_SOURCE)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SOURCE-1:0]      src_i,
    input  logic [N_SOURCE-1:0]      le_i,
    input  logic [N_TARGET-1:0]      claim_i,
    input  logic [N_TARGET*SRCW-1:0] claim_id_i,
    input  logic [N_TARGET-1:0]      complete_i,
    input  logic [N_TARGET*SRCW-1:0] complete_id_i,
    output logic [N_SOURCE-1:0]      ip_o,
    output logic [N_SOURCE-1:0]      ia_o
);

    logic [N_SOURCE-1:0] src_d;
    logic [N_SOURCE-1:0] src_q;
    logic [N_SOURCE-1:0] ip_d;
    logic [N_SOURCE-1:0] ip_q;
    logic [N_SOURCE-1:0] ia_d;
    logic [N_SOURCE-1:0] ia_q;
    logic [N_SOURCE-1:0] set_ev;
    logic [N_SOURCE-1:0] accept;
    logic [N_SOURCE-1:0] claim_hit;
    logic [N_SOURCE-1:0] complete_hit;

`ifdef RV_PLIC_GATEWAY_SYNC_EN
    logic [N_SOURCE-1:0] sync1_q;
    logic [N_SOURCE-1:0] sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_d = sync2_q;
`else
    assign src_d = src_i;
`endif

    rv_plic_gw_id_decode #(
        .N_SOURCE (N_SOURCE),
        .N_TARGET (N_TARGET),
        .SRCW     (SRCW)
    ) u_claim_dec (
        .strobe_i (claim_i),
        .id_i     (claim_id_i),
        .hit_o    (claim_hit)
    );

    rv_plic_gw_id_decode #(
        .N_SOURCE (N_SOURCE),
        .N_TARGET (N_TARGET),
        .SRCW     (SRCW)
    ) u_complete_dec (
        .strobe_i (complete_i),
        .id_i     (complete_id_i),
        .hit_o    (complete_hit)
    );

    always_comb begin
        set_ev = '0;
        for (int k = 0; k < N_SOURCE; k++) begin
            if (gw_mode_e'(le_i[k]) == GW_EDGE) begin
                set_ev[k] = src_d[k] & ~src_q[k];
            end else begin
                set_ev[k] = src_d[k];
            end
        end
    end

    // An in-service source swallows further set events until completed
    assign accept = set_ev & ~ia_q;

    // Accept needs ia=0 while a claim hit needs ip=1 (hence ia=1), so the
    // accept branch never masks a real claim.
    always_comb begin
        ip_d = ip_q;
        ia_d = ia_q;
        for (int k = 0; k < N_SOURCE; k++) begin
            if (accept[k]) begin
                ip_d[k] = 1'b1;
                ia_d[k] = 1'b1;
            end else if (claim_hit[k] && ip_q[k]) begin
                ip_d[k] = 1'b0;
            end else if (complete_hit[k] && ia_q[k] && !ip_q[k]) begin
                ia_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q <= '0;
            ip_q  <= '0;
            ia_q  <= '0;
        end else begin
            src_q <= src_d;
            ip_q  <= ip_d;
            ia_q  <= ia_d;
        end
    end

    assign ip_o = ip_q;
    assign ia_o = ia_q;

endmodule

// File: tb/tb_rv_plic_gateway_cc.sv
// tb/tb_rv_plic_gateway_cc.sv - scoreboard bench for rv_plic_gateway_cc with a behavioural gateway model
module tb_rv_plic_gateway_cc;

    localparam int NS = 32;
    localparam int NT = 2;
    localparam int W  = 6;
`ifdef RV_PLIC_GATEWAY_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam int LAT = DLY + 1;

    logic              clk;
    logic              rst_i;
    logic [NS-1:0]     src_i;
    logic [NS-1:0]     le_i;
    logic [NT-1:0]     claim_i;
    logic [NT*W-1:0]   claim_id_i;
    logic [NT-1:0]     complete_i;
    logic [NT*W-1:0]   complete_id_i;
    logic [NS-1:0]     ip_o;
    logic [NS-1:0]     ia_o;

    rv_plic_gateway_cc #(
        .N_SOURCE (NS),
        .N_TARGET (NT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .src_i         (src_i),
        .le_i          (le_i),
        .claim_i       (claim_i),
        .claim_id_i    (claim_id_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .ip_o          (ip_o),
        .ia_o          (ia_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endfunction

    // Staged stimulus, applied by tick() at the falling edge
    logic [NS-1:0]   st_src;
    logic [NS-1:0]   st_le;
    logic [NT-1:0]   st_claim;
    logic [NT*W-1:0] st_cid;
    logic [NT-1:0]   st_comp;
    logic [NT*W-1:0] st_pid;

    // Reference model: per-source pending/active bits and last seen source
    bit [NS-1:0]     m_ip;
    bit [NS-1:0]     m_ia;
    bit [NS-1:0]     m_prev;
    logic [NS-1:0]   hist[$];
    logic [63:0]     exp_q[$];

    task automatic model_reset();
        m_ip = '0;
        m_ia = '0;
        m_prev = '0;
        hist.delete();
        for (int i = 0; i < DLY; i++) hist.push_back('0);
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [NS-1:0] sd;
        hist.push_back(src_i);
        sd = hist.pop_front();
        for (int k = 0; k < NS; k++) begin
            bit set_e;
            bit clm;
            bit cmp;
            set_e = le_i[k] ? (sd[k] && !m_prev[k]) : sd[k];
            clm = 0;
            cmp = 0;
            for (int t = 0; t < NT; t++) begin
                if (claim_i[t] && int'(claim_id_i[t*W +: W]) == k + 1) clm = 1;
                if (complete_i[t] && int'(complete_id_i[t*W +: W]) == k + 1) cmp = 1;
            end
            if (set_e && !m_ia[k]) begin
                m_ip[k] = 1;
                m_ia[k] = 1;
            end else if (clm && m_ip[k]) begin
                m_ip[k] = 0;
            end else if (cmp && m_ia[k] && !m_ip[k]) begin
                m_ia[k] = 0;
            end
        end
        m_prev = sd;
    endtask

    task automatic tick();
        @(negedge clk);
        src_i         = st_src;
        le_i          = st_le;
        claim_i       = st_claim;
        claim_id_i    = st_cid;
        complete_i    = st_comp;
        complete_id_i = st_pid;
        model_step();
        exp_q.push_back({64'(m_ip) << 32} | 64'(m_ia));
        st_claim = '0;
        st_comp  = '0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_claim(input int t, input int id);
        st_claim[t] = 1'b1;
        st_cid[t*W +: W] = W'(id);
    endtask

    task automatic set_comp(input int t, input int id);
        st_comp[t] = 1'b1;
        st_pid[t*W +: W] = W'(id);
    endtask

    task automatic idle_inputs();
        st_src = '0; st_claim = '0; st_comp = '0; st_cid = '0; st_pid = '0;
        src_i = '0; claim_i = '0; complete_i = '0; claim_id_i = '0; complete_id_i = '0;
    endtask

    // Monitor: every clocked update of ip_o/ia_o is checked against the queue
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_i && exp_q.size() > 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_ip_ia", {ip_o, ia_o}, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        st_le = '0;
        le_i  = '0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ip", 64'(ip_o), 64'd0);
        chk("reset_ia", 64'(ia_o), 64'd0);
        rst_i = 1'b0;

        // Level source 3: pend, claim, complete, re-pend while held
        st_src = 32'h8;
        repeat (LAT) tick();
        settle();
        chk("lvl_ip3", 64'(ip_o[3]), 64'd1);
        chk("lvl_ia3", 64'(ia_o[3]), 64'd1);
        set_claim(0, 4);
        tick(); settle();
        chk("lvl_claim_ip3", 64'(ip_o[3]), 64'd0);
        chk("lvl_claim_ia3", 64'(ia_o[3]), 64'd1);
        set_comp(0, 4);
        tick(); settle();
        chk("lvl_comp_ia3", 64'(ia_o[3]), 64'd0);
        tick(); settle();
        chk("lvl_repend_ip3", 64'(ip_o[3]), 64'd1);
        st_src = '0;
        repeat (LAT) tick();
        set_claim(0, 4); tick();
        set_comp(0, 4); tick();
        repeat (2) tick();
        settle();
        chk("lvl_drained", {ip_o, ia_o}, 64'd0);

        // Edge source 0: pulse pends once, second pulse while active is lost
        st_le = 32'h1;
        tick();
        st_src = 32'h1; tick();
        st_src = '0;
        repeat (LAT - 1) tick();
        settle();
        chk("edge_ip0", 64'(ip_o[0]), 64'd1);
        repeat (2) tick();
        settle();
        chk("edge_held_ip0", 64'(ip_o[0]), 64'd1);
        st_src = 32'h1; tick();
        st_src = '0;
        repeat (LAT + 1) tick();
        set_claim(0, 1); tick();
        set_comp(0, 1); tick();
        repeat (3) tick();
        settle();
        chk("edge_done_ip0", 64'(ip_o[0]), 64'd0);
        chk("edge_done_ia0", 64'(ia_o[0]), 64'd0);

        // Complete before claim is ignored
        st_le = '0;
        st_src = 32'h8;
        repeat (LAT + 1) tick();
        set_comp(0, 4); tick(); settle();
        chk("early_comp_ip3", 64'(ip_o[3]), 64'd1);
        chk("early_comp_ia3", 64'(ia_o[3]), 64'd1);
        set_claim(0, 4); tick();
        set_comp(0, 4); tick(); settle();
        chk("late_comp_ia3", 64'(ia_o[3]), 64'd0);
        st_src = '0;
        repeat (LAT + 1) tick();
        set_claim(0, 4); tick();
        set_comp(0, 4); tick();

        // Invalid IDs with every source pending
        st_src = '1;
        repeat (LAT + 1) tick();
        settle();
        chk("all_pend_ip", 64'(ip_o), 64'hFFFF_FFFF);
        set_claim(0, 0); set_claim(1, 33); tick();
        set_comp(0, 0); set_comp(1, 33); tick(); settle();
        chk("bad_id_ip", 64'(ip_o), 64'hFFFF_FFFF);
        chk("bad_id_ia", 64'(ia_o), 64'hFFFF_FFFF);

        // Two targets in one cycle: distinct IDs, then the same ID
        set_claim(0, 2); set_claim(1, 5); tick(); settle();
        chk("dual_claim_ip", 64'(ip_o), 64'hFFFF_FFED);
        set_comp(0, 2); tick();
        tick(); settle();
        chk("repend_ip1", 64'(ip_o[1]), 64'd1);
        set_claim(0, 2); set_claim(1, 2); tick(); settle();
        chk("same_id_ip1", 64'(ip_o[1]), 64'd0);
        chk("same_id_ia1", 64'(ia_o[1]), 64'd1);

        // Asynchronous reset in mid-service
        rst_i = 1'b1;
        #1;
        chk("async_rst_ip", 64'(ip_o), 64'd0);
        chk("async_rst_ia", 64'(ia_o), 64'd0);
        st_le = '0; le_i = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        // Source rise to ip_o latency
        st_src = 32'h80;
        for (int i = 1; i <= LAT; i++) begin
            tick(); settle();
            chk("latency_ip7", 64'(ip_o[7]), (i == LAT) ? 64'd1 : 64'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            st_src = $urandom() & $urandom();
            if ($urandom_range(0, 15) == 0) st_le = $urandom();
            for (int t = 0; t < NT; t++) begin
                if ($urandom_range(0, 1) == 1)
                    set_claim(t, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(1, NS));
                if ($urandom_range(0, 1) == 1)
                    set_comp(t, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(1, NS));
            end
            tick();
        end
        settle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
